// File: rtl/fifo_16x3_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_16x3_if : producer/consumer bundle for the 3-deep FWFT FIFO    |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
interface fifo_16x3_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             write;
  logic [WIDTH-1:0] write_data;
  logic             read;
  logic [WIDTH-1:0] read_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write, write_data, read,
    input  read_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  write, write_data, read,
    output read_data, empty, full, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_16x3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_16x3 : 3-entry x 16-bit first-word-fall-through FIFO with     |
// |             sticky overflow/underflow flags                        |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module fifo_16x3 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  fifo_16x3_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] c_LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             w_empty, w_full, w_do_wr, w_do_rd;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_FULL_CNT);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign w_do_wr = bus.write & (~w_full | bus.read);
  assign w_do_rd = bus.read & ~w_empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (w_do_wr) wp_d = (wp_q == c_LAST_PTR) ? '0 : wp_q + 1'b1;
    if (w_do_rd) rp_d = (rp_q == c_LAST_PTR) ? '0 : rp_q + 1'b1;
    case ({w_do_wr, w_do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.write & ~w_do_wr) ovf_d = 1'b1;
    if (bus.read & ~w_do_rd)  unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (w_do_wr) mem_q[wp_q] <= bus.write_data;
    end
  end

  assign bus.read_data = mem_q[rp_q];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_16x3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_16x3 : queue-model scoreboard plus directed vectors for    |
// |                the 3-deep FWFT FIFO                                |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_fifo_16x3;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  fifo_16x3_if #(.WIDTH(16), .DEPTH(3)) bus ();

  fifo_16x3 #(.WIDTH(16), .DEPTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of stored words and two sticky bits.
  logic [15:0] m_q [$];
  logic        m_ovf;
  logic        m_unf;
  logic        en_cmp;
  logic        saw_full;
  int          max_cnt;

  initial begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      logic acc_w;
      logic acc_r;
      acc_r = bus.read && (m_q.size() > 0);
      acc_w = bus.write && ((m_q.size() < 3) || bus.read);
      if (bus.read && !acc_r)  m_unf = 1'b1;
      if (bus.write && !acc_w) m_ovf = 1'b1;
      if (acc_r) void'(m_q.pop_front());
      if (acc_w) m_q.push_back(bus.write_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("m.count", {30'd0, bus.count}, m_q.size());
      chk("m.empty", {31'd0, bus.empty}, {31'd0, m_q.size() == 0});
      chk("m.full", {31'd0, bus.full}, {31'd0, m_q.size() == 3});
      chk("m.overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      chk("m.underflow", {31'd0, bus.underflow}, {31'd0, m_unf});
      if (m_q.size() > 0) chk("m.head", {16'd0, bus.read_data}, {16'd0, m_q[0]});
      if (bus.full === 1'b1) saw_full = 1'b1;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that consumed it.
  task automatic step(input logic rs, input logic w, input logic [15:0] wd, input logic r);
    reset          = rs;
    bus.write      = w;
    bus.write_data = wd;
    bus.read       = r;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    en_cmp = 1'b0;
    saw_full = 1'b0;
    max_cnt = 0;
    reset = 1'b1;
    bus.write = 1'b0;
    bus.write_data = 16'h0;
    bus.read = 1'b0;

    do_reset();
    en_cmp = 1'b1;
    chk("rst.empty", {31'd0, bus.empty}, 32'd1);
    chk("rst.full", {31'd0, bus.full}, 32'd0);
    chk("rst.count", {30'd0, bus.count}, 32'd0);
    chk("rst.read_data", {16'd0, bus.read_data}, 32'h0);
    chk("rst.ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst.unf", {31'd0, bus.underflow}, 32'd0);

    // Fill and drain
    step(1'b0, 1'b1, 16'h0001, 1'b0);
    chk("fill.first_fallthrough", {16'd0, bus.read_data}, 32'h0001);
    step(1'b0, 1'b1, 16'h0002, 1'b0);
    step(1'b0, 1'b1, 16'h0003, 1'b0);
    chk("fill.full", {31'd0, bus.full}, 32'd1);
    chk("fill.count", {30'd0, bus.count}, 32'd3);
    chk("fill.head", {16'd0, bus.read_data}, 32'h0001);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("drain.1", {16'd0, bus.read_data}, 32'h0002);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("drain.2", {16'd0, bus.read_data}, 32'h0003);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("drain.empty", {31'd0, bus.empty}, 32'd1);

    // Overflow
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("ovf.flag", {31'd0, bus.overflow}, 32'd1);
    chk("ovf.count", {30'd0, bus.count}, 32'd3);
    chk("ovf.head0", {16'd0, bus.read_data}, 32'hA000);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("ovf.head1", {16'd0, bus.read_data}, 32'hA001);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("ovf.head2", {16'd0, bus.read_data}, 32'hA002);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("ovf.drained", {31'd0, bus.empty}, 32'd1);

    // Underflow, then simultaneous read+write on empty
    do_reset();
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("unf.flag", {31'd0, bus.underflow}, 32'd1);
    chk("unf.count", {30'd0, bus.count}, 32'd0);
    step(1'b0, 1'b1, 16'h1234, 1'b1);
    chk("unf.rw.count", {30'd0, bus.count}, 32'd1);
    chk("unf.rw.data", {16'd0, bus.read_data}, 32'h1234);

    // Reset beats simultaneous strobes
    step(1'b1, 1'b1, 16'h5555, 1'b1);
    chk("rstprio.count", {30'd0, bus.count}, 32'd0);
    chk("rstprio.unf", {31'd0, bus.underflow}, 32'd0);

    // Full with simultaneous read+write
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0010 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 16'h0013, 1'b1);
    chk("fullrw.count", {30'd0, bus.count}, 32'd3);
    chk("fullrw.ovf", {31'd0, bus.overflow}, 32'd0);
    chk("fullrw.head0", {16'd0, bus.read_data}, 32'h0011);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("fullrw.head1", {16'd0, bus.read_data}, 32'h0012);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("fullrw.head2", {16'd0, bus.read_data}, 32'h0013);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("fullrw.empty", {31'd0, bus.empty}, 32'd1);

    // Wrap and stress: idle, read, idle, write, idle, write
    do_reset();
    saw_full = 1'b0;
    max_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      case (c % 6)
        1:       step(1'b0, 1'b0, 16'(c), 1'b1);
        3, 5:    step(1'b0, 1'b1, 16'(c), 1'b0);
        default: step(1'b0, 1'b0, 16'(c), 1'b0);
      endcase
    end
    chk("stress.saw_full", {31'd0, saw_full}, 32'd1);
    chk("stress.ovf", {31'd0, bus.overflow}, 32'd1);
    chk("stress.max_le3", {31'd0, max_cnt <= 3}, 32'd1);

    @(negedge clk);
    en_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fifo_16x3.md
# fifo_16x3

Three-entry, 16-bit-wide synchronous first-word-fall-through FIFO. It buffers recovered S/PDIF audio words between the decoder (producer) and the I2S serializer (consumer) in a single clock domain. The head entry is always presented on `read_data`, and a `read` strobe pops it. Writes to a full FIFO and reads from an empty FIFO are dropped and flagged.

## Interface
- `WIDTH`, 16, data word width in bits.
- `DEPTH`, 3, number of storage entries; need not be a power of two.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `write` input 1: push strobe, one word per cycle while high.
- `write_data` input WIDTH: word pushed when `write` is accepted.
- `read` input 1: pop strobe, one word per cycle while high.
- `read_data` output WIDTH: current head entry (show-ahead).
- `empty` output 1: high when count == 0.
- `full` output 1: high when count == DEPTH.
- `count` output 2: number of stored words, 0..3.
- `overflow` output 1: sticky; set when a write is dropped.
- `underflow` output 1: sticky; set when a read is dropped.

## Operation
- Storage is DEPTH registers of WIDTH bits, plus a write pointer `wp`, a read pointer `rp` and `count`.
- Pointers range 0..DEPTH-1 and wrap explicitly: after DEPTH-1 the next value is 0. No modulo-2^n wrap.
- Accept conditions:
  - `do_wr = write & (!full | read)`.
  - `do_rd = read & !empty`.
- A push writes `mem[wp] <= write_data` and advances `wp`.
- A pop advances `rp`.
- Count update:
  - `count` increments on push only.
  - `count` decrements on pop only.
  - `count` is unchanged when both occur or neither occurs.
- Boundary cases:
  - **Full, write only:** write dropped; `overflow` <= 1; memory and pointers unchanged.
  - **Full, read + write:** both occur; `count` stays 3; the written word goes into the slot freed by the pop.
  - **Empty, read only:** read dropped; `underflow` <= 1.
  - **Empty, read + write:** write accepted, read dropped; `underflow` <= 1; `count` becomes 1.
- `read_data = mem[rp]` combinationally.
  - When `empty`, it shows the stale slot, and the consumer must ignore it.
- `empty` and `full` decode combinationally from `count`.
- `overflow` and `underflow` are cleared only by reset.
- Reset state: `wp`=0, `rp`=0, `count`=0, all memory words 0, `overflow`=0, `underflow`=0.
  - Resulting outputs: `empty`=1, `full`=0, `read_data`=0.
- Reset mid-operation discards all contents; reset has priority over `write` and `read` in the same cycle.

## Timing
- Write-to-read latency is one cycle. A word pushed at edge N appears on `read_data` after edge N if the FIFO was empty; `empty` falls after edge N.
- A pop at edge N shows the next entry on `read_data` after edge N.
- Flags and `count` update on the same edge as the operation that changes them; there is no lookahead.
- Strobes are level-sampled per cycle: a `write` held high for k cycles attempts k pushes.
- There is no combinational path from `write` or `read` to any output.

## Test plan
- **Reset:** hold `reset` 3 cycles -> `empty`=1, `full`=0, `count`=0, `read_data`=0, both sticky flags 0.
- **Fill and drain:** write 0x0001, 0x0002, 0x0003 on consecutive cycles -> `full`=1, `count`=3, `read_data`=0x0001. Then read 3 times -> `read_data` steps 0x0002, 0x0003, then `empty`=1.
- **Overflow:** fill with 0xA000..0xA002, then write 0xBEEF -> `overflow`=1, `count`=3. A subsequent drain returns 0xA000, 0xA001, 0xA002 with no 0xBEEF.
- **Underflow and empty simultaneous:** read on an empty FIFO -> `underflow`=1, `count`=0. Then assert read and write 0x1234 in the same cycle -> `count`=1, `read_data`=0x1234.
- **Full simultaneous:** with the FIFO full of 0x0010..0x0012, assert read and write 0x0013 in the same cycle -> `count`=3, `overflow` stays 0, drain order 0x0011, 0x0012, 0x0013.
- **Wrap and stress:** repeat the cycle pattern idle, read, idle, write, idle, write for about 200 cycles with `write_data` = cycle counter. Required response:
  - every popped word equals the oldest accepted word (scoreboard);
  - pointers wrap through 2 -> 0 with no corruption;
  - `full` is reached;
  - excess writes set `overflow`;
  - `count` never exceeds 3.
